// File: rtl/display_3482bs_scan.sv
// Time-multiplexed scan driver for a 4-digit common-anode 3482BS seven-segment module.
// Register values are double-buffered and swapped in only at the frame boundary.
module display_3482bs_scan #(
  parameter int unsigned SLOT_UNIT = 6250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic [3:0]  bright,
  input  logic        enable,
  output logic        update_pending,
  output logic        frame_tick,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int unsigned UW = (SLOT_UNIT > 1) ? $clog2(SLOT_UNIT) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(SLOT_UNIT - 1);

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  bright;
    logic        enable;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RESET = '{digits: 16'h0000, dp: 4'h0, blank: 4'hF,
                                      bright: 4'hF, enable: 1'b0};

  logic [UW-1:0] unit_q, unit_d;
  logic [3:0]    phase_q, phase_d;
  logic [1:0]    digit_q, digit_d;
  disp_cfg_t     pend_q, pend_d;
  disp_cfg_t     act_q, act_d;
  logic          pend_flag_q, pend_flag_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_tick_q, frame_tick_d;

  disp_cfg_t     in_c;
  logic          unit_last_c;
  logic          lfc_c;
  logic          lit_c;
  logic [3:0]    nibble_c;

  // Active-high a..g pattern for one hex nibble
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    in_c         = '{digits: digits, dp: dp, blank: blank, bright: bright, enable: enable};
    unit_last_c  = (unit_q == UNIT_LAST);
    lfc_c        = unit_last_c && (phase_q == 4'hF) && (digit_q == 2'd3);

    unit_d       = unit_last_c ? '0 : unit_q + UW'(1);
    phase_d      = phase_q;
    digit_d      = digit_q;
    if (unit_last_c) begin
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'hF) begin
        digit_d = digit_q + 2'd1;
      end
    end

    // A load landing on the last frame cycle bypasses the pending set
    pend_d       = pend_q;
    pend_flag_d  = pend_flag_q;
    act_d        = act_q;
    if (lfc_c) begin
      pend_flag_d = 1'b0;
      if (load) begin
        act_d = in_c;
      end else if (pend_flag_q) begin
        act_d = pend_q;
      end
    end else if (load) begin
      pend_d      = in_c;
      pend_flag_d = 1'b1;
    end

    nibble_c     = act_q.digits[{digit_q, 2'b00} +: 4];
    lit_c        = act_q.enable && !act_q.blank[digit_q] && (phase_q <= act_q.bright);

    an_n_d       = 4'hF;
    seg_n_d      = 7'h7F;
    dp_n_d       = 1'b1;
    if (lit_c) begin
      an_n_d  = ~(4'b0001 << digit_q);
      seg_n_d = ~seg_decode(nibble_c);
      dp_n_d  = ~act_q.dp[digit_q];
    end
    frame_tick_d = (unit_q == '0) && (phase_q == 4'h0) && (digit_q == 2'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      unit_q       <= '0;
      phase_q      <= 4'h0;
      digit_q      <= 2'd0;
      pend_q       <= '0;
      act_q        <= CFG_RESET;
      pend_flag_q  <= 1'b0;
      an_n_q       <= 4'hF;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      unit_q       <= unit_d;
      phase_q      <= phase_d;
      digit_q      <= digit_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      pend_flag_q  <= pend_flag_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign update_pending = pend_flag_q;
  assign frame_tick     = frame_tick_q;
  assign an_n           = an_n_q;
  assign seg_n          = seg_n_q;
  assign dp_n           = dp_n_q;

endmodule

// File: tb/tb_display_3482bs_scan.sv
// Bench for display_3482bs_scan: a frame-position model predicts every pin each cycle,
// plus scenario-specific checks on the observed waveform.
module tb_display_3482bs_scan;

  localparam int SU    = 2;
  localparam int SLOT  = 16 * SU;
  localparam int FRAME = 4 * SLOT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  bright = 4'h0;
  logic        enable = 1'b0;
  logic        update_pending;
  logic        frame_tick;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  always #5 clock = ~clock;

  display_3482bs_scan #(.SLOT_UNIT(SU)) dut (
    .clock(clock), .reset(reset), .load(load), .digits(digits), .dp(dp),
    .blank(blank), .bright(bright), .enable(enable),
    .update_pending(update_pending), .frame_tick(frame_tick),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  int checks = 0;
  int errors = 0;
  logic [13:0] sb[$];

  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: k = non-reset edges since last reset, i.e. current frame position
  int          k = 0;
  logic [15:0] m_dig, p_dig;
  logic [3:0]  m_dp, m_blank, m_bright, p_dp, p_blank, p_bright;
  logic        m_en, p_en, p_flag;

  function automatic logic [13:0] obs();
    return {an_n, seg_n, dp_n, frame_tick, update_pending};
  endfunction

  task automatic push_model();
    logic [13:0] e;
    int p, d, ph;
    logic [3:0] nib;
    e = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
    if (reset) begin
      k = 0; p_flag = 1'b0;
      m_dig = 16'h0; m_dp = 4'h0; m_blank = 4'hF; m_bright = 4'hF; m_en = 1'b0;
      p_dig = 16'h0; p_dp = 4'h0; p_blank = 4'h0; p_bright = 4'h0; p_en = 1'b0;
    end else begin
      p  = k % FRAME;
      d  = p / SLOT;
      ph = (p % SLOT) / SU;
      if (m_en && !m_blank[d] && (ph <= int'(m_bright))) begin
        nib = m_dig[4*d +: 4];
        e[13:10] = ~(4'b0001 << d);
        e[9:3]   = ~dec[nib];
        e[2]     = ~m_dp[d];
      end
      e[1] = (p == 0);
      if (p == FRAME - 1) begin
        if (load) begin
          m_dig = digits; m_dp = dp; m_blank = blank; m_bright = bright; m_en = enable;
        end else if (p_flag) begin
          m_dig = p_dig; m_dp = p_dp; m_blank = p_blank; m_bright = p_bright; m_en = p_en;
        end
        p_flag = 1'b0;
      end else if (load) begin
        p_dig = digits; p_dp = dp; p_blank = blank; p_bright = bright; p_en = enable;
        p_flag = 1'b1;
      end
      e[0] = p_flag;
      k++;
    end
    sb.push_back(e);
  endtask

  task automatic cyc();
    push_model();
    @(posedge clock);
    #1;
  endtask

  function automatic int pos_now();
    return (k + FRAME - 1) % FRAME;
  endfunction

  function automatic int lead(input int target);
    return (target - (k % FRAME) + FRAME) % FRAME;
  endfunction

  task automatic set_cfg(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl,
                         input logic [3:0] br, input logic en);
    digits = dg; dp = dpv; blank = bl; bright = br; enable = en;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    reset = 1'b1; load = 1'b1;
    set_cfg(16'hDEAD, 4'hF, 4'h0, 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset c%0d got %h exp %h", i, obs(), e); end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic test_idle();
    logic [13:0] e;
    int ft[$];
    int lit;
    lit = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL idle c%0d got %h exp %h", i, obs(), e); end
      if (frame_tick) ft.push_back(i + 1);
      if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) lit++;
    end
    checks++;
    if (ft.size() != 3 || ft[0] != 1 || ft[1] != 129 || ft[2] != 257) begin
      errors++; $display("FAIL idle_tick count %0d first %0d exp 3 ticks at 1,129,257",
                         ft.size(), (ft.size() > 0) ? ft[0] : -1);
    end
    checks++;
    if (lit != 0) begin errors++; $display("FAIL idle_dark lit cycles %0d exp 0", lit); end
  endtask

  task automatic test_basic_load();
    logic [13:0] e;
    logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] exp_sg [4] = '{~7'h66, ~7'h4F, ~7'h5B, ~7'h06};
    logic       exp_dp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int L, n, pos, s;
    logic seen, applied;
    L = lead(10); n = 0; seen = 1'b0; applied = 1'b0;
    set_cfg(16'h1234, 4'b0100, 4'h0, 4'hF, 1'b1);
    for (int i = 0; i < L + 2 * FRAME + 2; i++) begin
      load = (i == L);
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL basic c%0d got %h exp %h", i, obs(), e); end
      pos = pos_now();
      if (i == L) begin
        checks++;
        if (update_pending !== 1'b1) begin errors++; $display("FAIL basic_pend got %b exp 1", update_pending); end
      end
      if (applied && n < FRAME) begin
        n++;
        if (pos % SLOT == 5) begin
          s = pos / SLOT; checks++;
          if (an_n !== exp_an[s] || seg_n !== exp_sg[s] || dp_n !== exp_dp[s]) begin
            errors++; $display("FAIL basic_slot%0d got %h/%h/%b exp %h/%h/%b", s, an_n, seg_n, dp_n,
                               exp_an[s], exp_sg[s], exp_dp[s]);
          end
        end
      end
      if (update_pending) seen = 1'b1;
      else if (seen) applied = 1'b1;
    end
    load = 1'b0;
  endtask

  task automatic test_brightness();
    logic [13:0] e;
    int L, n, pos;
    int cnt [4];
    logic seen, applied;
    L = lead(10); n = 0; seen = 1'b0; applied = 1'b0;
    cnt = '{0, 0, 0, 0};
    set_cfg(16'hFFFF, 4'h0, 4'h0, 4'h3, 1'b1);
    for (int i = 0; i < L + 2 * FRAME + 2; i++) begin
      load = (i == L);
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL bright c%0d got %h exp %h", i, obs(), e); end
      pos = pos_now();
      if (applied && n < FRAME) begin
        n++;
        if (an_n !== 4'hF && (pos % SLOT) < 8) cnt[pos / SLOT]++;
        if (an_n !== 4'hF && (pos % SLOT) >= 8) cnt[pos / SLOT] += 100;
      end
      if (update_pending) seen = 1'b1;
      else if (seen) applied = 1'b1;
    end
    load = 1'b0;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (cnt[s] != 8) begin errors++; $display("FAIL bright_slot%0d lit score %0d exp 8", s, cnt[s]); end
    end
  endtask

  task automatic test_blank_enable();
    logic [13:0] e;
    int L, n, odd, d0, tot;
    logic seen, applied;
    L = lead(10); n = 0; odd = 0; d0 = 0; seen = 1'b0; applied = 1'b0;
    set_cfg(16'h1234, 4'h0, 4'b1010, 4'hF, 1'b1);
    for (int i = 0; i < L + 2 * FRAME + 2; i++) begin
      load = (i == L);
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL blank c%0d got %h exp %h", i, obs(), e); end
      if (applied && n < FRAME) begin
        n++;
        if (an_n == 4'hD || an_n == 4'h7) odd++;
        if (an_n == 4'hE) d0++;
      end
      if (update_pending) seen = 1'b1;
      else if (seen) applied = 1'b1;
    end
    checks++;
    if (odd != 0 || d0 != SLOT) begin
      errors++; $display("FAIL blank_slots odd-lit %0d digit0-lit %0d exp 0 and %0d", odd, d0, SLOT);
    end
    L = lead(10); n = 0; tot = 0; seen = 1'b0; applied = 1'b0;
    set_cfg(16'h1234, 4'hF, 4'h0, 4'hF, 1'b0);
    for (int i = 0; i < L + 2 * FRAME + 2; i++) begin
      load = (i == L);
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL enable c%0d got %h exp %h", i, obs(), e); end
      if (applied && n < FRAME) begin
        n++;
        if (an_n !== 4'hF || dp_n !== 1'b1) tot++;
      end
      if (update_pending) seen = 1'b1;
      else if (seen) applied = 1'b1;
    end
    load = 1'b0;
    checks++;
    if (tot != 0) begin errors++; $display("FAIL enable_off lit cycles %0d exp 0", tot); end
  endtask

  task automatic test_double_load();
    logic [13:0] e;
    int L1, L2, a_hits, b_hits;
    L1 = lead(10); L2 = L1 + 20; a_hits = 0; b_hits = 0;
    for (int i = 0; i < L1 + 2 * FRAME + 2; i++) begin
      load = (i == L1) || (i == L2);
      if (i == L1) set_cfg(16'hAAAA, 4'h0, 4'h0, 4'hF, 1'b1);
      if (i == L2) set_cfg(16'hBBBB, 4'h0, 4'h0, 4'hF, 1'b1);
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL dbl c%0d got %h exp %h", i, obs(), e); end
      if (seg_n == ~7'h77) a_hits++;
      if (seg_n == ~7'h7C) b_hits++;
    end
    load = 1'b0;
    checks++;
    if (a_hits != 0 || b_hits < FRAME) begin
      errors++; $display("FAIL dbl_lastwins A-cycles %0d B-cycles %0d exp 0 and >=%0d", a_hits, b_hits, FRAME);
    end
  endtask

  task automatic test_lfc_load();
    logic [13:0] e;
    int L, up;
    L = lead(FRAME - 1); up = 0;
    set_cfg(16'h8765, 4'h0, 4'h0, 4'hF, 1'b1);
    for (int i = 0; i < L + 40; i++) begin
      load = (i == L);
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL lfc c%0d got %h exp %h", i, obs(), e); end
      if (update_pending) up++;
      if (i == L + 1) begin
        checks++;
        if (an_n !== 4'hE || seg_n !== ~7'h6D || frame_tick !== 1'b1) begin
          errors++; $display("FAIL lfc_apply got %h/%h/%b exp e/%h/1", an_n, seg_n, frame_tick, ~7'h6D);
        end
      end
    end
    load = 1'b0;
    checks++;
    if (up != 0) begin errors++; $display("FAIL lfc_pending high cycles %0d exp 0", up); end
  endtask

  task automatic test_mid_reset();
    logic [13:0] e;
    int L1, L2, lit;
    L1 = lead(20); L2 = L1 + 54; lit = 0;
    for (int i = 0; i < L2 + 301; i++) begin
      load  = (i == L1) || (i == L2);
      reset = (i == L2);
      if (i == L1) set_cfg(16'h9999, 4'hF, 4'h0, 4'hF, 1'b1);
      if (i == L2) set_cfg(16'h5555, 4'hF, 4'h0, 4'hF, 1'b1);
      if (i == L2 - 1) begin
        checks++;
        if (update_pending !== 1'b1) begin errors++; $display("FAIL mrst_pend got %b exp 1", update_pending); end
      end
      cyc(); e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL mrst c%0d got %h exp %h", i, obs(), e); end
      if (i == L2) begin
        checks++;
        if (update_pending !== 1'b0 || an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
          errors++; $display("FAIL mrst_dark got %b/%h/%h/%b exp 0/f/7f/1", update_pending, an_n, seg_n, dp_n);
        end
      end
      if (i > L2 && (an_n !== 4'hF || update_pending !== 1'b0)) lit++;
    end
    load = 1'b0; reset = 1'b0;
    checks++;
    if (lit != 0) begin errors++; $display("FAIL mrst_stale lit/pending cycles %0d exp 0", lit); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic_load();
    test_brightness();
    test_blank_enable();
    test_double_load();
    test_lfc_load();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
